// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int AW_DEF          = 16;
  localparam int DW_DEF          = 16;
  localparam int MAX_DSTREAK_DEF = 3;
  localparam int TIMEOUT_DEF     = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_I = 2'd1,
    ST_WAIT_D = 2'd2
  } state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_ctr.sv
// Loadable up-counter with a terminal flag at MAX; optionally saturates there.
module arb_timeout_ctr #(
  parameter int W   = 4,
  parameter int MAX = 15,
  parameter bit SAT = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (inc_i && !(SAT && tc_o))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and data
// access, with a bounded data-priority streak and a memory-ack timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int MAX_DSTREAK = MAX_DSTREAK_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ready_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ready_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          stall_f_o,
  output logic          stall_m_o,
  output logic          err_o,
  input  logic          err_clr_i
);

  localparam int SW = cnt_width(MAX_DSTREAK);
  localparam int WW = cnt_width(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          if_ready_q, if_ready_d, d_ready_q, d_ready_d;
  logic          err_q, err_d;
  logic          grant, own, timeout, d_win;
  logic          streak_tc, wait_tc;

  // Data wins unless it has already taken MAX_DSTREAK grants ahead of a waiting fetch.
  assign d_win = d_req_i && (!streak_tc || !if_req_i);

  arb_timeout_ctr #(.W(SW), .MAX(MAX_DSTREAK), .SAT(1'b1)) u_streak_ctr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (grant && (own == OWN_I || !if_req_i)),
    .load_val_i ('0),
    .inc_i      (grant && own == OWN_D && if_req_i),
    .tc_o       (streak_tc)
  );

  // Terminal count marks the TIMEOUT-th wait cycle without an ack.
  arb_timeout_ctr #(.W(WW), .MAX(TIMEOUT - 1), .SAT(1'b0)) u_wait_ctr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (grant),
    .load_val_i ('0),
    .inc_i      (state_q != ST_IDLE && !mem_ack_i),
    .tc_o       (wait_tc)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    grant       = 1'b0;
    own         = OWN_I;
    timeout     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A requester whose ready is high this cycle is not granted again.
        if (d_win) begin
          if (!d_ready_q) begin
            grant = 1'b1;
            own   = OWN_D;
          end
        end else if (if_req_i && !if_ready_q) begin
          grant = 1'b1;
          own   = OWN_I;
        end
        if (grant) begin
          mem_req_d = 1'b1;
          if (own == OWN_D) begin
            state_d     = ST_WAIT_D;
            mem_we_d    = d_we_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
          end else begin
            state_d    = ST_WAIT_I;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr_i;
          end
        end
      end
      default: begin
        if (mem_ack_i || wait_tc) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          timeout   = !mem_ack_i;
          if (state_q == ST_WAIT_I) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_ack_i ? mem_rdata_i : '0;
          end else begin
            d_ready_d = 1'b1;
            if (!mem_ack_i)     d_rdata_d = '0;
            else if (!mem_we_q) d_rdata_d = mem_rdata_i;
          end
        end
      end
    endcase
    err_d = timeout ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign d_ready_o   = d_ready_q;
  assign err_o       = err_q;
  assign stall_f_o   = if_req_i & ~if_ready_q;
  assign stall_m_o   = d_req_i & ~d_ready_q;

endmodule
